// File: rtl/dm_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dm_pipe
//  Purpose  : Single-port data memory with per-byte write enables, a
//             valid/ready request port, fixed read latency RD_LAT and a
//             sequential clear engine that fills every word with CLR_VAL.
//  Revision : 1.0  initial release
// ============================================================================
module dm_pipe #(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 32,
  parameter int                DEPTH   = 65536,
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_start,
  output logic                busy,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int                BE_W     = DATA_W / 8;
  localparam int                CLR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(DEPTH - 1);
  // Compare one bit wider than the address so DEPTH == 2**ADDR_W still fits.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [CLR_W-1:0]   clr_addr, clr_addr_n;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept;
  logic               in_range;
  logic               rd_acc;
  logic               wr_acc;
  logic [CLR_W-1:0]   mem_idx;
  logic [DATA_W-1:0]  rd_word;

  // Read pipeline: stage RD_LAT-1 is the response register itself.
  logic [RD_LAT-1:0]  pv;
  logic [RD_LAT-1:0]  pe;
  logic [DATA_W-1:0]  pd [RD_LAT];

  assign accept    = req_valid & req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_X);
  assign rd_acc    = accept & ~req_write;
  assign wr_acc    = accept & req_write & in_range;
  assign mem_idx   = req_addr[CLR_W-1:0];
  assign rd_word   = in_range ? mem[mem_idx] : '0;

  assign rsp_valid = pv[RD_LAT-1];
  assign rsp_err   = pe[RD_LAT-1];
  assign rsp_rdata = pd[RD_LAT-1];

  // State and clear-address registers; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_n;
      clr_addr <= clr_addr_n;
    end
  end

  // Next-state logic: walk the clear address, or wait for a clear request.
  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    busy       = 1'b0;
    req_ready  = 1'b0;
    case (state)
      CLEAR: begin
        busy       = 1'b1;
        clr_addr_n = clr_addr + CLR_W'(1);
        if (clr_addr == CLR_LAST) begin
          state_n    = IDLE;
          clr_addr_n = '0;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
        if (clr_start) begin
          state_n    = CLEAR;
          clr_addr_n = '0;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  // Memory array: clear-engine writes, otherwise byte-masked request writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= CLR_VAL;
      end else if (wr_acc) begin
        for (int b = 0; b < BE_W; b++) begin
          if (req_be[b]) begin
            mem[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read pipeline: data is captured at accept and only moves with its valid,
  // so the last stage holds the previous response while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc) begin
        pd[0] <= rd_word;
        pe[0] <= ~in_range;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
          pe[i] <= pe[i-1];
        end
      end
    end
  end

endmodule
`default_nettype wire
